// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/bubble sequencer for the IF/ID/EXE/MEM/WB pipeline.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RUN       | normal issue; load-use, EXE busy and redirects handled here
// MEM_WAIT  | data memory outstanding, whole pipe frozen, redirect parked
// FLUSH     | extra IF/ID flush cycles covering fetch latency after redirect
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rs1_load_use_i,
  input  logic       rs2_load_use_i,
  input  logic       EXE_busy_i,
  input  logic       MEM_busy_i,
  input  logic       redirect_i,
  output logic       IF_stall_o,
  output logic       ID_stall_o,
  output logic       EXE_stall_o,
  output logic       MEM_stall_o,
  output logic       ID_bubble_o,
  output logic       EXE_bubble_o,
  output logic       IF_flush_o,
  output logic       ID_flush_o,
  output logic [1:0] state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_count_o
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic       redirect_pend_q, redirect_pend_d;

  logic if_stall, id_stall, exe_stall, mem_stall;
  logic id_bubble, exe_bubble, if_flush, id_flush;
  logic redirect_take;

  always_comb begin
    state_d         = state_q;
    flush_cnt_d     = flush_cnt_q;
    redirect_pend_d = redirect_pend_q;
    if_stall        = 1'b0;
    id_stall        = 1'b0;
    exe_stall       = 1'b0;
    mem_stall       = 1'b0;
    id_bubble       = 1'b0;
    exe_bubble      = 1'b0;
    if_flush        = 1'b0;
    id_flush        = 1'b0;
    redirect_take   = 1'b0;

    if (MEM_busy_i) begin
      // Freeze everything; a redirect seen now is replayed once memory is done.
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      exe_stall = 1'b1;
      mem_stall = 1'b1;
      state_d   = ST_MEM_WAIT;
      if (redirect_i) begin
        redirect_pend_d = 1'b1;
      end
    end else if (redirect_i || redirect_pend_q) begin
      if_flush        = 1'b1;
      id_flush        = 1'b1;
      redirect_take   = 1'b1;
      redirect_pend_d = 1'b0;
      if (FLUSH_CYCLES > 1) begin
        state_d     = ST_FLUSH;
        flush_cnt_d = FLUSH_RELOAD;
      end else begin
        state_d     = ST_RUN;
        flush_cnt_d = 3'd0;
      end
    end else if (state_q == ST_FLUSH) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
      if (EXE_busy_i) begin
        exe_stall  = 1'b1;
        exe_bubble = 1'b1;
      end
      if (flush_cnt_q <= 3'd1) begin
        state_d     = ST_RUN;
        flush_cnt_d = 3'd0;
      end else begin
        flush_cnt_d = flush_cnt_q - 3'd1;
      end
    end else begin
      if (EXE_busy_i) begin
        if_stall   = 1'b1;
        id_stall   = 1'b1;
        exe_stall  = 1'b1;
        exe_bubble = 1'b1;
      end else if (rs1_load_use_i || rs2_load_use_i) begin
        if_stall  = 1'b1;
        id_stall  = 1'b1;
        id_bubble = 1'b1;
      end
      // A wait that interrupted a flush resumes the remaining flush cycles.
      if (state_q == ST_MEM_WAIT && flush_cnt_q != 3'd0) begin
        state_d = ST_FLUSH;
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= ST_RUN;
      flush_cnt_q     <= 3'd0;
      redirect_pend_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_cnt_q     <= flush_cnt_d;
      redirect_pend_q <= redirect_pend_d;
    end
  end

  assign IF_stall_o   = if_stall   & ~rst_i;
  assign ID_stall_o   = id_stall   & ~rst_i;
  assign EXE_stall_o  = exe_stall  & ~rst_i;
  assign MEM_stall_o  = mem_stall  & ~rst_i;
  assign ID_bubble_o  = id_bubble  & ~rst_i;
  assign EXE_bubble_o = exe_bubble & ~rst_i;
  assign IF_flush_o   = if_flush   & ~rst_i;
  assign ID_flush_o   = id_flush   & ~rst_i;
  assign state_o      = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (IF_stall_o) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (redirect_take) begin
      flush_count_d = flush_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (FLUSH_CYCLES=2): vector table plus
// hand-written reset and perf-counter sequences, checked through a scoreboard.
module tb_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       rs1_load_use_i, rs2_load_use_i, EXE_busy_i, MEM_busy_i, redirect_i;
  logic       IF_stall_o, ID_stall_o, EXE_stall_o, MEM_stall_o;
  logic       ID_bubble_o, EXE_bubble_o, IF_flush_o, ID_flush_o;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_o, flush_count_o;
`endif

  hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rs1_load_use_i (rs1_load_use_i),
    .rs2_load_use_i (rs2_load_use_i),
    .EXE_busy_i     (EXE_busy_i),
    .MEM_busy_i     (MEM_busy_i),
    .redirect_i     (redirect_i),
    .IF_stall_o     (IF_stall_o),
    .ID_stall_o     (ID_stall_o),
    .EXE_stall_o    (EXE_stall_o),
    .MEM_stall_o    (MEM_stall_o),
    .ID_bubble_o    (ID_bubble_o),
    .EXE_bubble_o   (EXE_bubble_o),
    .IF_flush_o     (IF_flush_o),
    .ID_flush_o     (ID_flush_o),
    .state_o        (state_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles_o (stall_cycles_o),
    .flush_count_o  (flush_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // input bits {rs1, rs2, exe, mem, redirect}
  localparam logic [4:0] I_NONE = 5'b00000;
  localparam logic [4:0] I_RS1  = 5'b10000;
  localparam logic [4:0] I_RS2  = 5'b01000;
  localparam logic [4:0] I_EXE  = 5'b00100;
  localparam logic [4:0] I_MEM  = 5'b00010;
  localparam logic [4:0] I_RED  = 5'b00001;
  // output bits {IF_st, ID_st, EXE_st, MEM_st, ID_bub, EXE_bub, IF_fl, ID_fl}
  localparam logic [7:0] O_NONE  = 8'b0000_0000;
  localparam logic [7:0] O_LU    = 8'b1100_1000;
  localparam logic [7:0] O_EXE   = 8'b1110_0100;
  localparam logic [7:0] O_MEM   = 8'b1111_0000;
  localparam logic [7:0] O_FL    = 8'b0000_0011;
  localparam logic [7:0] O_FLEXE = 8'b0010_0111;

  typedef struct {
    logic [4:0] in;
    logic [7:0] out;
    logic [1:0] st;
  } vec_t;

  typedef struct {
    logic [7:0] out;
    logic [1:0] st;
    string      tag;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic logic [7:0] out_vec();
    return {IF_stall_o, ID_stall_o, EXE_stall_o, MEM_stall_o,
            ID_bubble_o, EXE_bubble_o, IF_flush_o, ID_flush_o};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] in);
    {rs1_load_use_i, rs2_load_use_i, EXE_busy_i, MEM_busy_i, redirect_i} = in;
  endtask

  // Drive one cycle, queue its expectation, compare at the falling edge.
  task automatic step(input logic [4:0] in, input logic [7:0] out,
                      input logic [1:0] st, input string tag);
    exp_t e;
    @(posedge clk_i);
    #1;
    drive(in);
    e.out = out;
    e.st  = st;
    e.tag = tag;
    exp_q.push_back(e);
    @(negedge clk_i);
    if (exp_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, ".out"}, 32'(out_vec()), 32'(e.out));
      chk({e.tag, ".state"}, 32'(state_o), 32'(e.st));
    end
  endtask

  task automatic add(input logic [4:0] in, input logic [7:0] out, input logic [1:0] st);
    vec_t v;
    v.in  = in;
    v.out = out;
    v.st  = st;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    add(I_NONE,                     O_NONE,  2'd0); // 0
    add(I_RS1,                      O_LU,    2'd0);
    add(I_NONE,                     O_NONE,  2'd0);
    add(I_RS2,                      O_LU,    2'd0);
    add(I_EXE,                      O_EXE,   2'd0);
    add(I_EXE | I_RS2,              O_EXE,   2'd0); // 5
    add(I_RED,                      O_FL,    2'd0);
    add(I_NONE,                     O_FL,    2'd2);
    add(I_NONE,                     O_NONE,  2'd0);
    add(I_MEM,                      O_MEM,   2'd0);
    add(I_MEM | I_RED,              O_MEM,   2'd1); // 10
    add(I_MEM,                      O_MEM,   2'd1);
    add(I_NONE,                     O_FL,    2'd1);
    add(I_RS1,                      O_FL,    2'd2);
    add(I_NONE,                     O_NONE,  2'd0);
    add(I_RED | I_EXE | I_RS1,      O_FL,    2'd0); // 15
    add(I_EXE,                      O_FLEXE, 2'd2);
    add(I_RED,                      O_FL,    2'd0);
    add(I_RED,                      O_FL,    2'd2);
    add(I_NONE,                     O_FL,    2'd2);
    add(I_NONE,                     O_NONE,  2'd0); // 20
    add(I_MEM,                      O_MEM,   2'd0);
    add(I_RS1,                      O_LU,    2'd1);
    add(I_NONE,                     O_NONE,  2'd0);
    add(I_NONE,                     O_NONE,  2'd0);
    add(I_MEM | I_EXE | I_RS1 | I_RED, O_MEM, 2'd0); // 25
    add(I_NONE,                     O_FL,    2'd1);
    add(I_MEM,                      O_MEM,   2'd2);
    add(I_NONE,                     O_NONE,  2'd1);
    add(I_NONE,                     O_FL,    2'd2);
    add(I_NONE,                     O_NONE,  2'd0); // 30

    rst_i = 1'b1;
    drive(I_RS1 | I_MEM | I_RED);
    #2;
    chk("reset.out", 32'(out_vec()), 32'(O_NONE));
    chk("reset.state", 32'(state_o), 32'd0);
    drive(I_NONE);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].in, vecs[i].out, vecs[i].st, $sformatf("vec%0d", i));
    end

    // Reset landing in FLUSH with one flush cycle left.
    step(I_RED, O_FL, 2'd0, "rstfl.redir");
    @(posedge clk_i);
    #1;
    drive(I_NONE);
    chk("rstfl.pre.out", 32'(out_vec()), 32'(O_FL));
    chk("rstfl.pre.state", 32'(state_o), 32'd2);
    rst_i = 1'b1;
    #1;
    chk("rstfl.rst.out", 32'(out_vec()), 32'(O_NONE));
    chk("rstfl.rst.state", 32'(state_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    step(I_NONE, O_NONE, 2'd0, "rstfl.after0");
    step(I_NONE, O_NONE, 2'd0, "rstfl.after1");

    // Reset during MEM_WAIT discards the parked redirect.
    step(I_MEM | I_RED, O_MEM, 2'd0, "rstmw.park");
    step(I_MEM, O_MEM, 2'd1, "rstmw.wait");
    rst_i = 1'b1;
    #1;
    chk("rstmw.rst.out", 32'(out_vec()), 32'(O_NONE));
    drive(I_NONE);
    @(negedge clk_i);
    rst_i = 1'b0;
    step(I_NONE, O_NONE, 2'd0, "rstmw.after0");
    step(I_NONE, O_NONE, 2'd0, "rstmw.after1");

`ifdef HAZARD_PERF_CNT_EN
    rst_i = 1'b1;
    #1;
    chk("perf.rst.stall", stall_cycles_o, 32'd0);
    chk("perf.rst.flush", flush_count_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    step(I_RS1, O_LU, 2'd0, "perf.lu0");
    step(I_RS2, O_LU, 2'd0, "perf.lu1");
    step(I_EXE, O_EXE, 2'd0, "perf.exe");
    step(I_MEM, O_MEM, 2'd0, "perf.mem");
    step(I_NONE, O_NONE, 2'd1, "perf.exit");
    step(I_RED, O_FL, 2'd0, "perf.red0");
    step(I_NONE, O_FL, 2'd2, "perf.fl0");
    step(I_RED, O_FL, 2'd0, "perf.red1");
    step(I_NONE, O_FL, 2'd2, "perf.fl1");
    step(I_NONE, O_NONE, 2'd0, "perf.idle");
    chk("perf.stall_cycles", stall_cycles_o, 32'd4);
    chk("perf.flush_count", flush_count_o, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
